// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light sequencer family: phase encoding
// and the default phase durations in timebase ticks.
package traffic_pkg;

  typedef enum logic [1:0] {
    ALLRED = 2'b00,
    GREEN  = 2'b01,
    YELLOW = 2'b10
  } phase_e;

  localparam int DEF_GREEN_TICKS  = 20;
  localparam int DEF_YELLOW_TICKS = 4;
  localparam int DEF_ALLRED_TICKS = 2;

endpackage

// File: rtl/rr_next_dir.sv
// Combinational round-robin selector: first requesting approach after active_dir,
// wrapping, with active_dir itself last; no demand falls back to active_dir+1.
module rr_next_dir #(
  parameter  int NUM_DIR = 2,
  localparam int DIR_W   = $clog2(NUM_DIR)
) (
  input  logic [NUM_DIR-1:0] sensor,
  input  logic [DIR_W-1:0]   active_dir,
  output logic [DIR_W-1:0]   next_dir
);

  localparam int              SUM_W = DIR_W + 1;
  localparam logic [SUM_W-1:0] N_W  = SUM_W'(NUM_DIR);

  logic [2*NUM_DIR-1:0] doubled;
  logic [NUM_DIR-1:0]   rotated;
  logic [SUM_W-1:0]     start;
  logic [SUM_W-1:0]     offset;
  logic [SUM_W-1:0]     sum;

  always_comb begin
    // NOTE: every variable written here is assigned a default first, so no path can infer a latch.
    doubled = {sensor, sensor};
    start   = {1'b0, active_dir} + SUM_W'(1);
    // rotated[i] is the demand of approach (active_dir + 1 + i) mod NUM_DIR.
    rotated = NUM_DIR'(doubled >> start);
    offset  = '0;
    for (int i = NUM_DIR - 1; i >= 0; i--) begin
      if (rotated[i]) offset = SUM_W'(i);
    end
    sum      = start + offset;
    next_dir = (sum >= N_W) ? DIR_W'(sum - N_W) : DIR_W'(sum);
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// N-approach traffic-light sequencer with all-red clearance and demand-skipping round-robin.
// Define PREEMPT_EN to add the preempt / preempt_dir emergency-vehicle inputs.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter  int NUM_DIR      = 2,
  parameter  int CNT_W        = 8,
  parameter  int GREEN_TICKS  = DEF_GREEN_TICKS,
  parameter  int YELLOW_TICKS = DEF_YELLOW_TICKS,
  parameter  int ALLRED_TICKS = DEF_ALLRED_TICKS,
  localparam int DIR_W        = $clog2(NUM_DIR)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [NUM_DIR-1:0] sensor,
`ifdef PREEMPT_EN
  input  logic               preempt,
  input  logic [DIR_W-1:0]   preempt_dir,
`endif
  output logic [NUM_DIR-1:0] green,
  output logic [NUM_DIR-1:0] yellow,
  output logic [NUM_DIR-1:0] red,
  output logic [DIR_W-1:0]   active_dir,
  output logic               phase_done
);

  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_TICKS - 1);

  phase_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIR_W-1:0]   dir_q, dir_d;
  logic               done_q, done_d;
  logic [DIR_W-1:0]   rr_dir, green_dir;
  logic [NUM_DIR-1:0] dir_mask;
  logic               handover, preempt_now, preempt_hold;

  rr_next_dir #(.NUM_DIR(NUM_DIR)) u_rr (
    .sensor    (sensor),
    .active_dir(dir_q),
    .next_dir  (rr_dir)
  );

  assign dir_mask = NUM_DIR'(1) << dir_q;
  // Green extends only when the served approach is the sole one asking.
  assign handover = (sensor != dir_mask);

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= ALLRED;
      cnt_q   <= '0;
      dir_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

`ifdef PREEMPT_EN
  logic             pend_q;
  logic [DIR_W-1:0] pend_dir_q;

  assign preempt_now  = preempt && (dir_q != preempt_dir);
  assign preempt_hold = preempt;
  assign green_dir    = pend_q ? pend_dir_q : rr_dir;

  // Remember the preempting approach so the following clearance hands green to it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= 1'b0;
      pend_dir_q <= '0;
    end else if (state_q == GREEN && preempt_now) begin
      pend_q     <= 1'b1;
      pend_dir_q <= preempt_dir;
    end else if (state_q == ALLRED && state_d == GREEN) begin
      pend_q     <= 1'b0;
    end
  end
`else
  assign preempt_now  = 1'b0;
  assign preempt_hold = 1'b0;
  assign green_dir    = rr_dir;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    case (state_q)
      ALLRED: begin
        if (tick) begin
          if (cnt_q == ALLRED_LAST) begin
            state_d = GREEN;
            cnt_d   = '0;
            dir_d   = green_dir;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      GREEN: begin
        if (preempt_now) begin
          state_d = YELLOW;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else if (tick) begin
          // Timer saturates at its last value while green is being extended.
          if (cnt_q != GREEN_LAST) begin
            cnt_d = cnt_q + 1'b1;
          end else if (handover && !preempt_hold) begin
            state_d = YELLOW;
            cnt_d   = '0;
            done_d  = 1'b1;
          end
        end
      end
      YELLOW: begin
        if (tick) begin
          if (cnt_q == YELLOW_LAST) begin
            state_d = ALLRED;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ALLRED;
        cnt_d   = '0;
      end
    endcase
  end

  assign green      = (state_q == GREEN)  ? dir_mask : '0;
  assign yellow     = (state_q == YELLOW) ? dir_mask : '0;
  assign red        = ~(green | yellow);
  assign active_dir = dir_q;
  assign phase_done = done_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: a 2-approach and a 4-approach instance share clk/rst/tick
// and are compared against a phase-level model (remaining-ticks countdown per phase).
module tb_traffic_light_ctrl;

  localparam int GT = 20;
  localparam int YT = 4;
  localparam int AT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, tick;
  logic [1:0] sensor2;
  logic [3:0] sensor4;
  logic [1:0] g2, y2, r2;
  logic       ad2, pd2;
  logic [3:0] g4, y4, r4;
  logic [1:0] ad4;
  logic       pd4;
`ifdef PREEMPT_EN
  logic       preempt;
  logic       pdir2;
  logic [1:0] pdir4;
`endif

  logic [14:0] act2, act4;
  assign act2 = {7'b0, g2, y2, r2, ad2, pd2};
  assign act4 = {g4, y4, r4, ad4, pd4};

  int checks = 0;
  int errors = 0;
  int tcyc   = 0;

  traffic_light_ctrl #(.NUM_DIR(2)) dut2 (
    .clk(clk), .rst(rst), .tick(tick), .sensor(sensor2),
`ifdef PREEMPT_EN
    .preempt(preempt), .preempt_dir(pdir2),
`endif
    .green(g2), .yellow(y2), .red(r2), .active_dir(ad2), .phase_done(pd2)
  );

  traffic_light_ctrl #(.NUM_DIR(4)) dut4 (
    .clk(clk), .rst(rst), .tick(tick), .sensor(sensor4),
`ifdef PREEMPT_EN
    .preempt(preempt), .preempt_dir(pdir4),
`endif
    .green(g4), .yellow(y4), .red(r4), .active_dir(ad4), .phase_done(pd4)
  );

  // ---------------- reference model ----------------
  typedef enum int {M_RED, M_GRN, M_YEL} mphase_e;
  typedef struct {
    mphase_e ph;
    int      left;
    int      dir;
    bit      done;
    bit      pend;
    int      pend_dir;
  } model_t;

  model_t m2, m4;

  function automatic int pick(int n, logic [3:0] s, int cur);
    for (int k = 1; k <= n; k++) if (s[(cur + k) % n]) return (cur + k) % n;
    return (cur + 1) % n;
  endfunction

  function automatic bit wants_handover(int n, logic [3:0] s, int cur);
    for (int j = 0; j < n; j++) if (j != cur && s[j]) return 1'b1;
    return !s[cur];
  endfunction

  function automatic model_t model_next(model_t m, int n, bit r, bit t, logic [3:0] s,
                                        bit pre, int pdir);
    model_t x = m;
    x.done = 1'b0;
    if (r) begin
      x.ph = M_RED; x.left = AT; x.dir = 0; x.pend = 1'b0;
      return x;
    end
    case (m.ph)
      M_RED: if (t) begin
        x.left = m.left - 1;
        if (x.left == 0) begin
          x.ph = M_GRN; x.left = GT; x.done = 1'b1;
          x.dir = m.pend ? m.pend_dir : pick(n, s, m.dir);
          x.pend = 1'b0;
        end
      end
      M_GRN: begin
        if (pre && m.dir != pdir) begin
          x.ph = M_YEL; x.left = YT; x.done = 1'b1; x.pend = 1'b1; x.pend_dir = pdir;
        end else if (t) begin
          if (m.left > 1) x.left = m.left - 1;
          else if (!pre && wants_handover(n, s, m.dir)) begin
            x.ph = M_YEL; x.left = YT; x.done = 1'b1;
          end
        end
      end
      default: if (t) begin
        x.left = m.left - 1;
        if (x.left == 0) begin
          x.ph = M_RED; x.left = AT; x.done = 1'b1;
        end
      end
    endcase
    return x;
  endfunction

  function automatic logic [14:0] expect_out(model_t m, int n);
    logic [3:0] g, y, r;
    g = '0; y = '0;
    if (m.ph == M_GRN) g[m.dir] = 1'b1;
    if (m.ph == M_YEL) y[m.dir] = 1'b1;
    r = ~(g | y);
    if (n == 2) return {7'b0, g[1:0], y[1:0], r[1:0], m.dir[0], m.done};
    return {g, y, r, m.dir[1:0], m.done};
  endfunction

  // One clock: model consumes the inputs seen at the edge, outputs sampled 1ns later.
  task automatic step();
    bit r, t, pre;
    logic [1:0] s2;
    logic [3:0] s4;
    int p2, p4;
    r = rst; t = tick; s2 = sensor2; s4 = sensor4;
    pre = 1'b0; p2 = 0; p4 = 0;
`ifdef PREEMPT_EN
    pre = preempt; p2 = int'(pdir2); p4 = int'(pdir4);
`endif
    @(posedge clk);
    m2 = model_next(m2, 2, r, t, {2'b00, s2}, pre, p2);
    m4 = model_next(m4, 4, r, t, s4, pre, p4);
    #1;
  endtask

  task automatic step3();
    tick = (tcyc % 3 == 0);
    tcyc++;
    step();
  endtask

  // ---------------- per-cycle invariants ----------------
  logic [1:0] last_y2 = '0;
  logic [3:0] last_y4 = '0;
  always @(negedge clk) begin
    checks++;
    if (!$onehot0(g2 | y2) || (r2 !== ~(g2 | y2)) || (last_y2 != 2'b0 && g2 != 2'b0)) begin
      errors++;
      $display("FAIL invariant_n2 t=%0t green=%b yellow=%b red=%b prev_yellow=%b", $time, g2, y2, r2, last_y2);
    end
    checks++;
    if (!$onehot0(g4 | y4) || (r4 !== ~(g4 | y4)) || (last_y4 != 4'b0 && g4 != 4'b0)) begin
      errors++;
      $display("FAIL invariant_n4 t=%0t green=%b yellow=%b red=%b prev_yellow=%b", $time, g4, y4, r4, last_y4);
    end
    last_y2 <= y2;
    last_y4 <= y4;
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; tick = 1'b1; sensor2 = 2'b11; sensor4 = 4'b1111;
    step(); step();
    checks++;
    if (act2 !== {7'b0, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_n2 got=%b want=%b", act2, {7'b0, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0});
    end
    checks++;
    if (act4 !== {4'b0000, 4'b0000, 4'b1111, 2'b00, 1'b0}) begin
      errors++; $display("FAIL reset_n4 got=%b want=%b", act4, {4'b0000, 4'b0000, 4'b1111, 2'b00, 1'b0});
    end
  endtask

  // Full phase-by-phase sequence under constant demand; dir advances by one each round.
  task automatic test_fixed_sequence(input int n, input int rounds, input string tag);
    int d;
    logic [10:0] act, exp;
    logic [3:0] eg, ey;
    rst = 1'b1; tick = 1'b1; step(); rst = 1'b0;
    d = 0;
    for (int r = 0; r < rounds; r++) begin
      for (int i = 0; i < AT + GT + YT; i++) begin
        if (i == AT) d = (d + 1) % n;
        eg  = (i >= AT && i < AT + GT) ? 4'(1 << d) : 4'b0;
        ey  = (i >= AT + GT) ? 4'(1 << d) : 4'b0;
        exp = {eg, ey, 2'(d), ((i == 0 && r > 0) || i == AT || i == AT + GT)};
        act = (n == 2) ? {2'b0, g2, 2'b0, y2, 1'b0, ad2, pd2} : {g4, y4, ad4, pd4};
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL %s round %0d cycle %0d green/yellow/dir/done got=%b want=%b", tag, r, i, act, exp);
        end
        step();
      end
    end
  endtask

  task automatic test_basic();
    sensor2 = 2'b11; sensor4 = 4'b0000;
    test_fixed_sequence(2, 3, "basic_n2");
  endtask

  task automatic test_rotation();
    sensor2 = 2'b00; sensor4 = 4'b0000;
    test_fixed_sequence(4, 5, "rotation_n4");
  endtask

  task automatic test_extend();
    int k;
    sensor4 = 4'b0000; rst = 1'b1; tick = 1'b1; step(); rst = 1'b0;
    k = 0;
    while (g4 !== 4'b0010 && k < 50) begin step(); k++; end
    checks++;
    if (g4 !== 4'b0010) begin errors++; $display("FAIL extend_first_green got=%b want=0010", g4); end
    sensor4 = 4'b0100;
    k = 0;
    while (g4 !== 4'b0100 && k < 100) begin step(); k++; end
    checks++;
    if ({g4, ad4} !== {4'b0100, 2'd2}) begin
      errors++; $display("FAIL extend_next_dir got green=%b dir=%0d want green=0100 dir=2", g4, ad4);
    end
    for (int i = 0; i < GT + 30; i++) begin
      step();
      checks++;
      if ({g4, pd4} !== {4'b0100, 1'b0}) begin
        errors++; $display("FAIL extend_hold cycle %0d got green=%b done=%b want 0100/0", i, g4, pd4);
      end
    end
    sensor4 = 4'b0101;
    step();
    checks++;
    if ({y4, pd4} !== {4'b0100, 1'b1}) begin
      errors++; $display("FAIL extend_release got yellow=%b done=%b want 0100/1", y4, pd4);
    end
  endtask

  task automatic test_tick3();
    int k, len;
    sensor2 = 2'b11; sensor4 = 4'b0011; tcyc = 0;
    rst = 1'b1; step3(); rst = 1'b0;
    k = 0;
    while (g2 == 2'b0 && k < 200) begin step3(); k++; end
    len = 0;
    while (g2 != 2'b0 && len < 200) begin step3(); len++; end
    checks++;
    if (len != 3 * GT) begin errors++; $display("FAIL tick3_green_len got=%0d want=%0d", len, 3 * GT); end
    len = 0;
    while (y2 != 2'b0 && len < 200) begin step3(); len++; end
    checks++;
    if (len != 3 * YT) begin errors++; $display("FAIL tick3_yellow_len got=%0d want=%0d", len, 3 * YT); end
    len = 0;
    while (g2 == 2'b0 && y2 == 2'b0 && len < 200) begin step3(); len++; end
    checks++;
    if (len != 3 * AT) begin errors++; $display("FAIL tick3_allred_len got=%0d want=%0d", len, 3 * AT); end
    k = 0;
    while (y2 == 2'b0 && k < 300) begin step3(); k++; end
    step3(); step3();
    checks++;
    if (y2 == 2'b0) begin errors++; $display("FAIL tick3_mid_yellow got yellow=%b want nonzero", y2); end
    rst = 1'b1; step3(); rst = 1'b0;
    checks++;
    if (act2 !== {7'b0, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0}) begin
      errors++; $display("FAIL tick3_reset got=%b want=%b", act2, {7'b0, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0});
    end
    for (int i = 0; i < 200; i++) begin
      step3();
      checks++;
      if (act2 !== expect_out(m2, 2)) begin
        errors++; $display("FAIL tick3_restart cycle %0d got=%b want=%b", i, act2, expect_out(m2, 2));
      end
    end
    tick = 1'b1;
  endtask

`ifdef PREEMPT_EN
  task automatic test_preempt();
    int k;
    preempt = 1'b0; pdir2 = 1'b1; pdir4 = 2'd0; sensor2 = 2'b01;
    rst = 1'b1; tick = 1'b1; step(); rst = 1'b0;
    k = 0;
    while (g2 !== 2'b01 && k < 20) begin step(); k++; end
    checks++;
    if (g2 !== 2'b01) begin errors++; $display("FAIL preempt_setup got green=%b want 01", g2); end
    repeat (5) step();
    preempt = 1'b1;
    step();
    checks++;
    if ({y2, pd2} !== {2'b01, 1'b1}) begin
      errors++; $display("FAIL preempt_yellow got yellow=%b done=%b want 01/1", y2, pd2);
    end
    for (int i = 1; i < YT + AT; i++) begin
      step();
      checks++;
      if ({g2, y2} !== {2'b00, (i < YT) ? 2'b01 : 2'b00}) begin
        errors++; $display("FAIL preempt_clear cycle %0d got green=%b yellow=%b", i, g2, y2);
      end
    end
    for (int i = 0; i < 50; i++) begin
      step();
      checks++;
      if (g2 !== 2'b10) begin errors++; $display("FAIL preempt_hold cycle %0d got green=%b want 10", i, g2); end
    end
    preempt = 1'b0;
  endtask
`endif

  task automatic test_random();
    rst = 1'b1; tick = 1'b1; step(); rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      tick = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 7) == 0) sensor2 = 2'($urandom);
      if ($urandom_range(0, 7) == 0) sensor4 = 4'($urandom);
      rst = ($urandom_range(0, 299) == 0);
`ifdef PREEMPT_EN
      if ($urandom_range(0, 99) == 0) preempt = ~preempt;
      if ($urandom_range(0, 49) == 0) begin pdir2 = 1'($urandom); pdir4 = 2'($urandom); end
`endif
      step();
      checks++;
      if (act2 !== expect_out(m2, 2)) begin
        errors++; $display("FAIL random_n2 cycle %0d got=%b want=%b", c, act2, expect_out(m2, 2));
      end
      checks++;
      if (act4 !== expect_out(m4, 4)) begin
        errors++; $display("FAIL random_n4 cycle %0d got=%b want=%b", c, act4, expect_out(m4, 4));
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b1; sensor2 = '0; sensor4 = '0;
`ifdef PREEMPT_EN
    preempt = 1'b0; pdir2 = 1'b0; pdir4 = '0;
`endif
    test_reset();
    test_basic();
    test_extend();
    test_rotation();
    test_tick3();
`ifdef PREEMPT_EN
    test_preempt();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
